// File: rtl/axi_resp_pkg.sv
// Shared AXI response/burst constants and FSM state types for the burst responder.
package axi_resp_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

endpackage

// File: rtl/sdp_ram64.sv
// Simple dual-port 64-bit RAM: byte-enabled write port, registered read port (read-before-write).
module sdp_ram64 #(
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [7:0]            wbe,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [63:0]           wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [63:0]           rdata
);

  logic [63:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    // Output register holds its value while re is low so a stalled beat survives.
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_burst_responder.sv
// AXI4 INCR-burst slave backed by on-chip RAM; optional ready-stall injection under AXI_STALL_INJECT_EN.
module axi4_burst_responder
  import axi_resp_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH_LOG2 = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h1000_0000)
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic [63:0]       WDATA,
  input  logic [7:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic              WLAST,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  output logic [63:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              RLAST
);

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] d;
    d = (a - BASE_ADDR) >> 3;
    return DEPTH_LOG2'(d);
  endfunction

  logic stall;
`ifdef AXI_STALL_INJECT_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) lfsr <= 16'hACE1;
    else            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Keeps the address readies low while reset is asserted.
  logic run;
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) run <= 1'b0;
    else            run <= 1'b1;
  end

  // ---------------- write channel ----------------
  wstate_e               w_state, w_next;
  logic [7:0]            w_cnt, w_len;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_legal, w_err, aw_hs, w_beat;

  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = RESP_OKAY;
    aw_hs   = 1'b0;
    w_beat  = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = run && !stall;
        aw_hs   = AWVALID && AWREADY;
        if (aw_hs) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = !stall;
        w_beat = WVALID && WREADY;
        if (w_beat && (w_cnt == w_len)) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = (!w_legal || w_err) ? RESP_SLVERR : RESP_OKAY;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_cnt <= '0;
        w_err <= 1'b0;
      end else if (w_beat) begin
        w_cnt <= w_cnt + 8'd1;
        if (WLAST != (w_cnt == w_len)) w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_idx   <= word_idx(AWADDR);
      w_len   <= AWLEN;
      w_legal <= (AWSIZE == SIZE_8B) && (AWBURST == BURST_INCR);
    end else if (w_beat) begin
      w_idx <= w_idx + 1'b1;
    end
  end

  // ---------------- read channel ----------------
  rstate_e               r_state, r_next;
  logic [7:0]            r_icnt, r_len;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_legal, r_pend, ar_hs;
  logic                  vld_p0, vld_p1, last_p1, load_p2;
  logic [63:0]           ram_q;

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    ar_hs   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = run && !stall;
        ar_hs   = ARVALID && ARREADY;
        if (ar_hs) r_next = R_DATA;
      end
      R_DATA: if (RVALID && RREADY && RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign load_p2 = (!RVALID || RREADY) && !stall;
  assign vld_p0  = r_pend && (!vld_p1 || load_p2);

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      r_idx   <= word_idx(ARADDR);
      r_len   <= ARLEN;
      r_legal <= (ARSIZE == SIZE_8B) && (ARBURST == BURST_INCR);
    end else if (vld_p0) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  sdp_ram64 #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (w_beat && w_legal),
    .wbe   (WSTRB),
    .waddr (w_idx),
    .wdata (WDATA),
    .re    (vld_p0),
    .raddr (r_idx),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= R_IDLE;
      r_pend  <= 1'b0;
      r_icnt  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RRESP   <= RESP_OKAY;
      RDATA   <= '0;
    end else begin
      r_state <= r_next;
      // p0: issue RAM read
      if (ar_hs) begin
        r_pend <= 1'b1;
        r_icnt <= '0;
      end else if (vld_p0) begin
        r_icnt <= r_icnt + 8'd1;
        if (r_icnt == r_len) r_pend <= 1'b0;
      end
      // p1: RAM output register
      if (vld_p0) begin
        vld_p1  <= 1'b1;
        last_p1 <= (r_icnt == r_len);
      end else if (load_p2) begin
        vld_p1 <= 1'b0;
      end
      // p2: AXI R output register
      if (load_p2) begin
        RVALID <= vld_p1;
        RLAST  <= vld_p1 && last_p1;
        RRESP  <= (vld_p1 && !r_legal) ? RESP_SLVERR : RESP_OKAY;
        RDATA  <= (vld_p1 && r_legal) ? ram_q : '0;
      end else if (RREADY) begin
        RVALID <= 1'b0;
        RLAST  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_responder.sv
// Directed scoreboard bench for axi4_burst_responder (default build).
module tb_axi4_burst_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          MASK = (1 << 16) - 1;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [7:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [63:0] WDATA, RDATA;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] mdl [int];
  logic [1:0]  bq [$];
  rbeat_t      rq [$];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_burst_responder dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) >> 3;
    return int'(d) & MASK;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_ctl"}, 64'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RRESP}), 64'd0);
    chk({tag, "_rdata"}, RDATA, 64'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input int len, input logic [1:0] burst,
                    input logic [2:0] size, input int lastpos, input int bdelay, input int abort_after);
    int n, idx;
    logic legal;
    logic [63:0] m;
    legal   = (size == 3'b011) && (burst == 2'b01);
    idx     = widx(addr);
    AWADDR  = addr; AWLEN = 8'(len); AWBURST = burst; AWSIZE = size; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 100) begin tick(); n++; end
    if (!AWREADY) begin chk("aw_timeout", 64'(AWREADY), 64'd1); AWVALID = 1'b0; return; end
    tick();
    AWVALID = 1'b0;
    bq.push_back((legal && lastpos == len) ? 2'b00 : 2'b10);
    for (int i = 0; i <= len; i++) begin
      if (i == abort_after) begin
        WVALID = 1'b0;
        void'(bq.pop_back());
        return;
      end
      WVALID = 1'b1; WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == lastpos);
      n = 0;
      while (!WREADY && n < 100) begin tick(); n++; end
      if (!WREADY) begin chk("w_timeout", 64'(WREADY), 64'd1); WVALID = 1'b0; return; end
      if (legal) begin
        m = mdl.exists(idx) ? mdl[idx] : 64'd0;
        for (int b = 0; b < 8; b++) if (ws[i][b]) m[8*b +: 8] = wd[i][8*b +: 8];
        mdl[idx] = m;
      end
      tick();
      idx = (idx + 1) & MASK;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    for (int k = 0; k < bdelay; k++) begin
      chk("bvalid_hold", 64'(BVALID), 64'd1);
      tick();
    end
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 100) begin tick(); n++; end
    if (!BVALID) chk("b_timeout", 64'(BVALID), 64'd1);
    else chk("bresp", 64'(BRESP), 64'(bq.pop_front()));
    tick();
    BREADY = 1'b0;
    chk("bvalid_drop", 64'(BVALID), 64'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input int len, input logic [1:0] burst,
                    input logic [2:0] size, input bit bp);
    int n, idx, hs_cyc, k;
    logic legal, first, prev_stall, prev_last, rr;
    logic [63:0] prev_d;
    logic [3:0] pat;
    rbeat_t e;
    pat   = 4'b1001;
    legal = (size == 3'b011) && (burst == 2'b01);
    idx   = widx(addr);
    for (int i = 0; i <= len; i++) begin
      e.d    = legal ? (mdl.exists(idx) ? mdl[idx] : 64'd0) : 64'd0;
      e.resp = legal ? 2'b00 : 2'b10;
      e.last = (i == len);
      rq.push_back(e);
      idx = (idx + 1) & MASK;
    end
    ARADDR = addr; ARLEN = 8'(len); ARBURST = burst; ARSIZE = size; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 100) begin tick(); n++; end
    if (!ARREADY) begin chk("ar_timeout", 64'(ARREADY), 64'd1); ARVALID = 1'b0; rq.delete(); return; end
    tick();
    hs_cyc = cyc;
    ARVALID = 1'b0;
    first = 1'b1; prev_stall = 1'b0; prev_last = 1'b0; prev_d = '0; k = 0; n = 0;
    while (rq.size() > 0 && n < 300) begin
      rr = (RVALID && bp && k < 4) ? pat[3-k] : 1'b1;
      RREADY = rr;
      if (prev_stall) begin
        chk("r_hold_valid", 64'(RVALID), 64'd1);
        chk("r_hold_data", RDATA, prev_d);
        chk("r_hold_last", 64'(RLAST), 64'(prev_last));
      end
      if (RVALID && first) begin
        chk("r_latency", 64'(cyc - hs_cyc), 64'd2);
        first = 1'b0;
      end
      if (RVALID && rr) begin
        e = rq.pop_front();
        chk("rdata", RDATA, e.d);
        chk("rresp", 64'(RRESP), 64'(e.resp));
        chk("rlast", 64'(RLAST), 64'(e.last));
      end
      prev_stall = RVALID && !rr;
      prev_d     = RDATA;
      prev_last  = RLAST;
      if (RVALID) k++;
      tick();
      n++;
    end
    if (rq.size() > 0) begin
      chk("r_timeout", 64'(rq.size()), 64'd0);
      rq.delete();
    end
    RREADY = 1'b0;
    chk("arready_after_rlast", 64'(ARREADY), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    AWADDR = '0; AWVALID = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    WDATA = '0; WSTRB = 0; WVALID = 0; WLAST = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;
    for (int i = 0; i < 256; i++) begin wd[i] = '0; ws[i] = 8'hFF; end
    tick();
    outputs_zero("reset");
    tick();
    sys_rst_n = 1'b1;
    tick(); tick();
    chk("awready_idle", 64'(AWREADY), 64'd1);
    chk("arready_idle", 64'(ARREADY), 64'd1);

    // basic write then read back
    for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
    wr(BASE, 3, 2'b01, 3'b011, 3, 0, -1);
    rd(BASE, 3, 2'b01, 3'b011, 1'b0);

    // byte strobes
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr(BASE, 0, 2'b01, 3'b011, 0, 0, -1);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    wr(BASE, 0, 2'b01, 3'b011, 0, 0, -1);
    ws[0] = 8'hFF;
    rd(BASE + 32'd3, 0, 2'b01, 3'b011, 1'b0);

    // wrap from last word to word 0
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; wd[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    wr(BASE + 32'h0007_FFF8, 1, 2'b01, 3'b011, 1, 0, -1);
    rd(BASE + 32'h0007_FFF8, 1, 2'b01, 3'b011, 1'b0);
    rd(BASE, 0, 2'b01, 3'b011, 1'b0);

    // illegal write burst type leaves RAM untouched
    wd[0] = 64'h1616_1616_1616_1616;
    wr(BASE + 32'd128, 0, 2'b01, 3'b011, 0, 0, -1);
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    wr(BASE + 32'd128, 0, 2'b00, 3'b011, 0, 0, -1);
    rd(BASE + 32'd128, 0, 2'b01, 3'b011, 1'b0);

    // early WLAST: 4 beats still consumed, error response
    for (int i = 0; i < 4; i++) wd[i] = 64'h5000 + 64'(i);
    wr(BASE + 32'd256, 3, 2'b01, 3'b011, 1, 0, -1);
    rd(BASE + 32'd256, 3, 2'b01, 3'b011, 1'b0);

    // illegal read size
    rd(BASE, 0, 2'b01, 3'b010, 1'b0);

    // backpressure on B and R
    for (int i = 0; i < 8; i++) wd[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 7 + 3);
    wr(BASE + 32'd512, 7, 2'b01, 3'b011, 7, 5, -1);
    rd(BASE + 32'd512, 7, 2'b01, 3'b011, 1'b1);

    // reset in the middle of a write burst
    for (int i = 0; i < 8; i++) wd[i] = 64'h0123_0000_0000_0000 | 64'(i);
    wr(BASE + 32'd1024, 7, 2'b01, 3'b011, 7, 0, -1);
    for (int i = 0; i < 8; i++) wd[i] = 64'h9876_0000_0000_0000 | 64'(i);
    wr(BASE + 32'd1024, 7, 2'b01, 3'b011, 7, 0, 2);
    sys_rst_n = 1'b0;
    #1;
    outputs_zero("reset_mid");
    tick(); tick();
    outputs_zero("reset_hold");
    sys_rst_n = 1'b1;
    tick(); tick();
    chk("no_bvalid_after_reset", 64'(BVALID), 64'd0);
    rd(BASE + 32'd1024, 7, 2'b01, 3'b011, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
